// File: rtl/pio_multi_shadow_out.sv
// Multi-channel Avalon-MM output PIO with shadow registers.
// Channels commit atomically to out_port on command or frame_sync.
module pio_multi_shadow_out #(
    parameter int unsigned    WIDTH     = 4,
    parameter int unsigned    NUM_CH    = 4,
    parameter int unsigned    ADDR_W    = 6,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    input  logic                    frame_sync,
    output logic [NUM_CH*WIDTH-1:0] out_port,
    output logic                    update_pulse
);

    localparam int unsigned CTRL_ADDR = 2 * NUM_CH;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q [NUM_CH];
    logic [WIDTH-1:0] shadow_d [NUM_CH];
    logic [WIDTH-1:0] active_q [NUM_CH];
    logic [WIDTH-1:0] active_d [NUM_CH];
    logic             dirty_q, dirty_d;
    logic             auto_q, auto_d;
    logic [7:0]       commit_cnt_q, commit_cnt_d;
    logic             update_pulse_q, update_pulse_d;

    logic wr;
    logic ctrl_wr;
    logic shadow_wr_any;
    logic commit;
    logic unused_wdata;

    assign unused_wdata = ^writedata;

    always_comb begin
        wr      = chipselect & ~write_n;
        ctrl_wr = wr && (address == ADDR_W'(CTRL_ADDR));
        shadow_wr_any = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr && (address == ADDR_W'(i))) begin
                shadow_d[i]   = writedata[WIDTH-1:0];
                shadow_wr_any = 1'b1;
            end
        end

        // auto uses the pre-edge value, so enabling it never commits by itself
        commit = (ctrl_wr && writedata[1])
               || ((state_q == ARMED) && frame_sync)
               || (auto_q && dirty_q && frame_sync);

        for (int i = 0; i < NUM_CH; i++) begin
            active_d[i] = commit ? shadow_q[i] : active_q[i];
        end
    end

    always_comb begin
        state_d        = state_q;
        dirty_d        = dirty_q;
        auto_d         = auto_q;
        commit_cnt_d   = commit_cnt_q;
        update_pulse_d = commit;

        if (commit) begin
            state_d      = IDLE;
            commit_cnt_d = commit_cnt_q + 8'd1;
        end else if (ctrl_wr && writedata[0]) begin
            state_d = ARMED;
        end

        if (ctrl_wr) begin
            auto_d = writedata[2];
        end

        // a shadow write racing a commit leaves the new value pending
        if (shadow_wr_any) begin
            dirty_d = 1'b1;
        end else if (commit) begin
            dirty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            dirty_q        <= 1'b0;
            auto_q         <= 1'b0;
            commit_cnt_q   <= 8'd0;
            update_pulse_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= RESET_VAL;
                active_q[i] <= RESET_VAL;
            end
        end else begin
            state_q        <= state_d;
            dirty_q        <= dirty_d;
            auto_q         <= auto_d;
            commit_cnt_q   <= commit_cnt_d;
            update_pulse_q <= update_pulse_d;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (address == ADDR_W'(i)) begin
                readdata[WIDTH-1:0] = shadow_q[i];
            end
            if (address == ADDR_W'(NUM_CH + i)) begin
                readdata[WIDTH-1:0] = active_q[i];
            end
        end
        if (address == ADDR_W'(CTRL_ADDR)) begin
            readdata[0]    = (state_q == ARMED);
            readdata[1]    = dirty_q;
            readdata[2]    = auto_q;
            readdata[15:8] = commit_cnt_q;
        end
    end

    always_comb begin
        out_port = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            out_port[i*WIDTH +: WIDTH] = active_q[i];
        end
    end

    assign update_pulse = update_pulse_q;

endmodule

// File: tb/tb_pio_multi_shadow_out.sv
// Directed self-checking bench for pio_multi_shadow_out.
// Inputs change on negedge; outputs are sampled just after.
module tb_pio_multi_shadow_out;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        frame_sync;
    logic [15:0] out_port;
    logic        update_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    pio_multi_shadow_out #(
        .WIDTH(4), .NUM_CH(4), .ADDR_W(6), .RESET_VAL(4'h0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .frame_sync(frame_sync),
        .out_port(out_port),
        .update_pulse(update_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d,
                      input logic fs);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        frame_sync = fs;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        frame_sync = 1'b0;
        #1;
    endtask

    task automatic fsync();
        @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        #1;
    endtask

    task automatic rd(input string tag, input logic [5:0] a,
                      input logic [31:0] exp);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        chk(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        frame_sync = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_out", {16'h0, out_port}, 32'h0);
        chk("rst_pulse", {31'h0, update_pulse}, 32'h0);
        rd("rst_stat", 6'd8, 32'h0);

        // shadow write then immediate commit
        wr(6'd1, 32'h9, 1'b0);
        rd("act1_pre", 6'd5, 32'h0);
        rd("stat_dirty", 6'd8, 32'h2);
        wr(6'd8, 32'h2, 1'b0);
        chk("now_out", {16'h0, out_port}, 32'h0090);
        chk("now_pulse", {31'h0, update_pulse}, 32'h1);
        tick();
        chk("now_pulse_end", {31'h0, update_pulse}, 32'h0);
        rd("now_stat", 6'd8, 32'h100);

        // arm, wait 20 cycles, frame_sync commits
        wr(6'd3, 32'h7, 1'b0);
        wr(6'd8, 32'h1, 1'b0);
        rd("arm_stat", 6'd8, 32'h103);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("arm_hold_out", {16'h0, out_port}, 32'h0090);
            chk("arm_hold_pulse", {31'h0, update_pulse}, 32'h0);
        end
        fsync();
        chk("fs_out", {16'h0, out_port}, 32'h7090);
        chk("fs_pulse", {31'h0, update_pulse}, 32'h1);
        rd("fs_stat", 6'd8, 32'h200);
        repeat (3) tick();
        fsync();
        chk("fs2_pulse", {31'h0, update_pulse}, 32'h0);
        chk("fs2_out", {16'h0, out_port}, 32'h7090);

        // auto mode: shadow write racing frame_sync does not commit
        wr(6'd8, 32'h4, 1'b0);
        chk("auto_pulse", {31'h0, update_pulse}, 32'h0);
        rd("auto_stat", 6'd8, 32'h204);
        wr(6'd0, 32'h3, 1'b1);
        chk("auto_race_pulse", {31'h0, update_pulse}, 32'h0);
        chk("auto_race_out", {16'h0, out_port}, 32'h7090);
        rd("auto_race_stat", 6'd8, 32'h206);
        fsync();
        chk("auto_out", {16'h0, out_port}, 32'h7093);
        chk("auto_cpulse", {31'h0, update_pulse}, 32'h1);
        rd("auto_cstat", 6'd8, 32'h304);

        // armed commit racing a shadow write
        wr(6'd8, 32'h0, 1'b0);
        wr(6'd2, 32'hC, 1'b0);
        wr(6'd8, 32'h1, 1'b0);
        rd("race_arm_stat", 6'd8, 32'h303);
        wr(6'd2, 32'h5, 1'b1);
        chk("race_out", {16'h0, out_port}, 32'h7C93);
        chk("race_pulse", {31'h0, update_pulse}, 32'h1);
        rd("race_stat", 6'd8, 32'h402);
        rd("race_shadow", 6'd2, 32'h5);
        wr(6'd8, 32'h3, 1'b0);
        chk("race_now_out", {16'h0, out_port}, 32'h7593);
        rd("race_now_stat", 6'd8, 32'h500);

        // reset while armed and pulse high
        wr(6'd1, 32'hE, 1'b0);
        wr(6'd8, 32'h1, 1'b0);
        fsync();
        chk("pre_rst_pulse", {31'h0, update_pulse}, 32'h1);
        wr(6'd8, 32'h1, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out", {16'h0, out_port}, 32'h0);
        chk("mid_rst_pulse", {31'h0, update_pulse}, 32'h0);
        rd("mid_rst_stat", 6'd8, 32'h0);
        rd("mid_rst_shadow", 6'd1, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        fsync();
        chk("post_rst_pulse", {31'h0, update_pulse}, 32'h0);

        // counter wrap and unmapped address
        wr(6'd0, 32'hF, 1'b0);
        for (int i = 0; i < 257; i++) begin
            wr(6'd8, 32'h2, 1'b0);
        end
        rd("wrap_stat", 6'd8, 32'h100);
        chk("wrap_out", {16'h0, out_port}, 32'h000F);
        wr(6'd9, 32'hFFFF_FFFF, 1'b0);
        chk("unmap_pulse", {31'h0, update_pulse}, 32'h0);
        rd("unmap_rd", 6'd9, 32'h0);
        rd("unmap_stat", 6'd8, 32'h100);
        wr(6'd6, 32'hA, 1'b0);
        rd("ro_active", 6'd6, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
